// File: rtl/gate_sweep_ctrl_pkg.sv
// Shared definitions for the gate sweep self-test controller: state encoding,
// vector count and the per-vector pass/fail rule of the NOR/OR pair.
package gate_sweep_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int VEC_COUNT = 4;

    // A vector fails when either gate output disagrees with the driven inputs.
    function automatic logic vec_fail(input logic a, input logic b,
                                      input logic y_nor, input logic y_or);
        logic any;
        any = a | b;
        return (y_nor != ~any) || (y_or != any);
    endfunction

endpackage

// File: rtl/gate_sweep_ctrl.sv
// Self-test sequencer for a 2-input NOR/OR pair: walks (a,b) through 00..11,
// holds each vector HOLD_CYCLES cycles, compares at the end of the hold.
module gate_sweep_ctrl
    import gate_sweep_ctrl_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int ERR_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             a_drv,
    output logic             b_drv,
    output logic [1:0]       vec_idx,
    input  logic             y_nor_in,
    input  logic             y_or_in,
    output logic [ERR_W-1:0] err_cnt,
    output logic             pass
);

    localparam int               HC_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;
    localparam logic [1:0]       VEC_LAST  = 2'(VEC_COUNT - 1);

    state_e            state_q, state_d;
    logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [1:0]        vec_idx_q, vec_idx_d;
    logic              a_drv_q, a_drv_d;
    logic              b_drv_q, b_drv_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic              pass_q, pass_d;

    logic cmp_cycle;
    logic last_vec;
    logic vec_bad;

    assign cmp_cycle = (state_q == ST_DRIVE) && (hold_cnt_q == HOLD_LAST);
    assign last_vec  = (vec_idx_q == VEC_LAST);
    assign vec_bad   = vec_fail(a_drv_q, b_drv_q, y_nor_in, y_or_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            vec_idx_q  <= '0;
            a_drv_q    <= 1'b0;
            b_drv_q    <= 1'b0;
            err_cnt_q  <= '0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            vec_idx_q  <= vec_idx_d;
            a_drv_q    <= a_drv_d;
            b_drv_q    <= b_drv_d;
            err_cnt_q  <= err_cnt_d;
            pass_q     <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_DRIVE;
            ST_DRIVE: if (cmp_cycle && last_vec) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath next-state. pass is resolved on the final compare edge so it
    // already reflects vector 3 while done is high.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        vec_idx_d  = vec_idx_q;
        err_cnt_d  = err_cnt_q;
        pass_d     = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    hold_cnt_d = '0;
                    vec_idx_d  = '0;
                    err_cnt_d  = '0;
                end
            end
            ST_DRIVE: begin
                if (cmp_cycle) begin
                    hold_cnt_d = '0;
                    if (vec_bad && (err_cnt_q != ERR_MAX))
                        err_cnt_d = err_cnt_q + ERR_W'(1);
                    if (!last_vec)
                        vec_idx_d = vec_idx_q + 2'd1;
                    else
                        pass_d = (err_cnt_d == '0);
                end else begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end
            end
            default: ;
        endcase
        a_drv_d = vec_idx_d[1];
        b_drv_d = vec_idx_d[0];
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_DRIVE: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

    assign a_drv   = a_drv_q;
    assign b_drv   = b_drv_q;
    assign vec_idx = vec_idx_q;
    assign err_cnt = err_cnt_q;
    assign pass    = pass_q;

endmodule

// File: doc/gate_sweep_ctrl.md
Name: gate_sweep_ctrl

Overview:
Sequencer that exhaustively exercises a 2-input NOR/OR gate pair in-system.
- Drives all four input combinations in order, holding each for a programmable settle time.
- Samples the gate outputs and checks them against expected values, then reports an error count and a pass flag through a start/done handshake.
- Sits beside the nor_or datapath as its self-test controller.

Parameters:
HOLD_CYCLES, 4, cycles each input vector is held before the compare; legal range >= 1
ERR_W, 4, width of the error counter; legal range >= 2

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request a sweep; sampled only in IDLE
busy  output  1  high while a sweep is in progress (DRIVE state)
done  output  1  one-cycle pulse when the sweep completes
a_drv  output  1  drive to gate input a
b_drv  output  1  drive to gate input b
vec_idx  output  2  index of the vector currently driven, 0..3
y_nor_in  input  1  observed NOR output of the gate
y_or_in  input  1  observed OR output of the gate
err_cnt  output  ERR_W  number of failing vectors, saturating
pass  output  1  1 when the last completed sweep had err_cnt == 0

Behaviour:
- The clock is clk. Reset is rst_n, asynchronous and active-low.
- Reset state: all outputs 0 (busy, done, a_drv, b_drv, vec_idx, err_cnt, pass). State = IDLE, hold_cnt = 0.
- The FSM has three states: IDLE, DRIVE and DONE.
- IDLE:
  - If start = 1 at a clock edge: go to DRIVE, set vec_idx = 0 and hold_cnt = 0, and clear err_cnt to 0.
  - pass keeps its previous value until the new sweep completes.
- DRIVE:
  - busy = 1.
  - a_drv = vec_idx[1] and b_drv = vec_idx[0], both registered, so the vector order is (a,b) = 00, 01, 10, 11.
  - hold_cnt increments every cycle.
  - Compare cycle: the cycle in which hold_cnt == HOLD_CYCLES-1.
    - Expected values: y_nor = ~(a_drv | b_drv) and y_or = a_drv | b_drv.
    - The vector fails if either observed output mismatches.
    - A failing vector increments err_cnt by 1, saturating at 2^ERR_W - 1.
  - After the compare cycle: hold_cnt returns to 0.
    - If vec_idx < 3, vec_idx increments.
    - If vec_idx == 3, the FSM goes to DONE.
- DONE:
  - Lasts exactly one cycle.
  - done = 1 and busy = 0.
  - pass is registered as (err_cnt_final == 0); the value includes the compare result of vector 3.
  - Next state is IDLE.
- Latency: start is sampled at edge k. DRIVE occupies cycles k+1 .. k+4*HOLD_CYCLES. done is high in cycle k+4*HOLD_CYCLES+1.
- start while busy or during DONE: ignored, with no restart and no queuing.
- start held high continuously: a new sweep begins on the cycle after DONE, since IDLE samples start.
- a_drv, b_drv and vec_idx hold the vector-3 values (1, 1, 3) in DONE and IDLE until the next sweep starts.
- err_cnt and pass hold after DONE until the next accepted start.
- Reset mid-sweep: all outputs go to 0 immediately and the FSM is in IDLE. No done pulse is produced.
- HOLD_CYCLES = 1: every DRIVE cycle is a compare cycle. The gate must settle within one cycle.

Decomposition:
- Shared package: state encoding constants (IDLE = 2'd0, DRIVE = 2'd1, DONE = 2'd2) and a VEC_COUNT = 4 constant.
- No sub-module inside the controller. The hold counter and the error counter stay inline.
- The test wrapper instantiates gate_sweep_ctrl and nor_or side by side. a_drv and b_drv connect to a and b; y_nor and y_or connect back to y_nor_in and y_or_in.

Test Plan:
1. Healthy nor_or, HOLD_CYCLES = 4: pulse start at cycle 0.
   -> busy for cycles 1-16, done pulse at cycle 17, err_cnt = 0, pass = 1, vec_idx visits 0,1,2,3 in 4-cycle steps.
2. y_or_in tied to 0 (stuck-at): one sweep.
   -> vectors 1, 2 and 3 fail, err_cnt = 3, pass = 0.
3. ERR_W = 2, both outputs inverted: one sweep.
   -> all 4 vectors fail, err_cnt saturates at 3, pass = 0.
4. Healthy gate: pulse start again at cycle 8 of a running sweep.
   -> ignored, done still at cycle 17, only one done pulse.
5. Assert rst_n = 0 at cycle 6 of a sweep, release at cycle 8, pulse start at cycle 10.
   -> all outputs 0 during reset, no done pulse, then a clean sweep with done at cycle 27 and pass = 1.
6. HOLD_CYCLES = 1, start held high for 12 cycles.
   -> back-to-back sweeps, done pulses at cycles 5 and 11, err_cnt cleared at the start of each sweep.
